// File: rtl/iq_stream_buf_pkg.sv
// iq_stream_buf_pkg
// Shared definitions for the I/Q stream buffer: sample width, the packed
// {I,Q} word layout and a helper that turns an address width into a depth.
package iq_stream_buf_pkg;

  localparam int IQ_DSZ = 16;

  // One buffered sample: I in the upper half, Q in the lower half.
  typedef struct packed {
    logic [IQ_DSZ-1:0] i;
    logic [IQ_DSZ-1:0] q;
  } iq_word_t;

  // Number of words addressable with an aw-bit address.
  function automatic int fifo_depth(input int aw);
    return 32'sd1 << aw;
  endfunction

endpackage

// File: rtl/iq_buf_ram.sv
// iq_buf_ram
// Simple dual-port RAM, 2^aw x dw, one write port and one registered read
// port. No reset on the array or read register so it maps onto block or
// distributed RAM.
// Ports:
//   clk        clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read strobe; rd_data_o updates on the edge where it is high
//   rd_addr_i  read address
//   rd_data_o  registered read data (holds when rd_en_i is low)
module iq_buf_ram
  import iq_stream_buf_pkg::*;
#(
  parameter int aw = 4,
  parameter int dw = 2 * IQ_DSZ
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [aw-1:0] wr_addr_i,
  input  logic [dw-1:0] wr_data_i,
  input  logic          rd_en_i,
  input  logic [aw-1:0] rd_addr_i,
  output logic [dw-1:0] rd_data_o
);

  logic [dw-1:0] mem_q [0:fifo_depth(aw)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; output holds between reads.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/iq_stream_buf.sv
// iq_stream_buf
// Elastic buffer behind the decimating downconverter. Each valid I/Q pair is
// packed as {I,Q} into a circular RAM FIFO and presented first-word-fall-
// through on a valid/ready stream with a registered output. Reports fill
// level and a sticky overflow flag.
// Optional feature macro: IQ_STREAM_BUF_OVF_CNT_EN adds a saturating 16-bit
// dropped-sample counter on port ovf_cnt.
// Ports:
//   clk, reset (async, active-high)
//   in_valid, i_in, q_in   sample input (one-cycle pulse)
//   flush                  synchronous clear of FIFO contents
//   ovf_clr                synchronous clear of overflow status
//   out_valid, out_ready, out_data  output stream ({I,Q})
//   level                  words held, 0..DEPTH
//   ovf                    sticky overflow
//   ovf_cnt                dropped-sample count (macro only)
module iq_stream_buf
  import iq_stream_buf_pkg::*;
#(
  parameter int dsz = IQ_DSZ,
  parameter int asz = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [dsz-1:0]   i_in,
  input  logic [dsz-1:0]   q_in,
  input  logic             flush,
  input  logic             ovf_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*dsz-1:0] out_data,
  output logic [asz:0]     level,
  output logic             ovf
`ifdef IQ_STREAM_BUF_OVF_CNT_EN
  ,
  output logic [15:0]      ovf_cnt
`endif
);

  localparam logic [asz:0] DEPTH_L = (asz + 1)'(fifo_depth(asz));
  localparam logic [asz:0] ONE_L   = (asz + 1)'(1);
  localparam logic [asz:0] ZERO_L  = (asz + 1)'(0);

  // Pointers carry one extra bit so wr - rd gives the RAM occupancy directly.
  logic [asz:0]     wr_ptr_q, wr_ptr_d;
  logic [asz:0]     rd_ptr_q, rd_ptr_d;
  logic [asz:0]     level_q, level_d;
  logic             s1_q, s1_d;            // RAM read register holds an unclaimed word
  logic             out_valid_q, out_valid_d;
  logic [2*dsz-1:0] out_data_q, out_data_d;
  logic             ovf_q, ovf_d;

  logic [asz:0]     ram_cnt_s;
  logic             full_s, pop_s, wr_s, drop_s, load_s, rd_s;
  logic [2*dsz-1:0] ram_rdata_s;

  // Handshake decode and next-state logic.
  always_comb begin
    ram_cnt_s = wr_ptr_q - rd_ptr_q;
    full_s    = (level_q == DEPTH_L);
    pop_s     = out_valid_q & out_ready;
    // Full blocks writes even when a pop happens on the same edge.
    wr_s      = in_valid & ~full_s & ~flush;
    drop_s    = in_valid & full_s & ~flush;
    // Move the RAM read register into the output stage when it is free.
    load_s    = s1_q & (~out_valid_q | pop_s);
    // Prefetch whenever the RAM read register is (or becomes) free.
    rd_s      = (ram_cnt_s != ZERO_L) & (~s1_q | load_s) & ~flush;

    if (flush) begin
      wr_ptr_d    = ZERO_L;
      rd_ptr_d    = ZERO_L;
      level_d     = ZERO_L;
      s1_d        = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end else begin
      wr_ptr_d    = wr_s ? (wr_ptr_q + ONE_L) : wr_ptr_q;
      rd_ptr_d    = rd_s ? (rd_ptr_q + ONE_L) : rd_ptr_q;
      case ({wr_s, pop_s})
        2'b10:   level_d = level_q + ONE_L;
        2'b01:   level_d = level_q - ONE_L;
        default: level_d = level_q;
      endcase
      if (rd_s) begin
        s1_d = 1'b1;
      end else if (load_s) begin
        s1_d = 1'b0;
      end else begin
        s1_d = s1_q;
      end
      if (load_s) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_rdata_s;
      end else if (pop_s) begin
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
      end else begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
      end
    end

    // A drop wins over a simultaneous clear.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= ZERO_L;
      rd_ptr_q    <= ZERO_L;
      level_q     <= ZERO_L;
      s1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {(2 * dsz){1'b0}};
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;
  assign ovf       = ovf_q;

`ifdef IQ_STREAM_BUF_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating drop counter; a drop during a clear restarts the count at 1.
  always_comb begin
    if (drop_s && ovf_clr) begin
      ovf_cnt_d = 16'd1;
    end else if (drop_s) begin
      ovf_cnt_d = (ovf_cnt_q == 16'hFFFF) ? ovf_cnt_q : (ovf_cnt_q + 16'd1);
    end else if (ovf_clr) begin
      ovf_cnt_d = 16'd0;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_cnt_q <= 16'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  iq_buf_ram #(
    .aw (asz),
    .dw (2 * dsz)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_s),
    .wr_addr_i (wr_ptr_q[asz-1:0]),
    .wr_data_i ({i_in, q_in}),
    .rd_en_i   (rd_s),
    .rd_addr_i (rd_ptr_q[asz-1:0]),
    .rd_data_o (ram_rdata_s)
  );

endmodule

// File: tb/tb_iq_stream_buf.sv
// Directed bench for iq_stream_buf with asz=3 (DEPTH=8). A queue model tracks
// expected contents, level and sticky overflow; outputs are sampled 1 time
// unit after each rising edge.
module tb_iq_stream_buf;

  localparam int DSZ   = 16;
  localparam int ASZ   = 3;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [DSZ-1:0]  i_in, q_in;
  logic            flush, ovf_clr;
  logic            out_valid, out_ready;
  logic [31:0]     out_data;
  logic [ASZ:0]    level;
  logic            ovf;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] sb [$];
  logic        ovf_exp = 1'b0;

  iq_stream_buf #(.dsz(DSZ), .asz(ASZ)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .i_in      (i_in),
    .q_in      (q_in),
    .flush     (flush),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs; model is updated and checked.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic rdy,
                     input logic fl, input logic clr);
    logic full;
    logic [31:0] exp_w;
    in_valid  = iv;
    i_in      = d[31:16];
    q_in      = d[15:0];
    out_ready = rdy;
    flush     = fl;
    ovf_clr   = clr;
    full      = (sb.size() == DEPTH);
    if (out_valid === 1'b1 && rdy && !fl) begin
      if (sb.size() == 0) begin
        chk("xfer_unexpected", 32'd1, 32'd0);
      end else begin
        exp_w = sb.pop_front();
        chk("xfer_data", out_data, exp_w);
      end
    end
    if (fl) begin
      sb.delete();
    end else if (iv && !full) begin
      sb.push_back(d);
    end
    if (iv && !fl && full) ovf_exp = 1'b1;
    else if (clr)          ovf_exp = 1'b0;
    @(posedge clk);
    #1;
    chk("level", 32'(level), 32'(sb.size()));
    chk("ovf", 32'(ovf), 32'(ovf_exp));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; i_in = '0; q_in = '0;
    flush = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Single sample, latency and hold
    cyc(1'b1, 32'h1234ABCD, 1'b0, 1'b0, 1'b0);
    chk("lat_n0_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lat_n1_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lat_n2_valid", 32'(out_valid), 32'd1);
    chk("lat_n2_data", out_data, 32'h1234ABCD);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data", out_data, 32'h1234ABCD);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("after_xfer_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ready_idle_valid", 32'(out_valid), 32'd0);

    // Overflow: 9 writes into 8 slots
    for (int k = 1; k <= 9; k++) cyc(1'b1, 32'(k), 1'b0, 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_set", 32'(ovf), 32'd1);
    // Full blocks a write even with a same-cycle transfer
    cyc(1'b1, 32'h0000_00AA, 1'b1, 1'b0, 1'b0);
    chk("full_rw_level", 32'(level), 32'd7);
    for (int k = 0; k < 12; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_level", 32'(level), 32'd0);

    // Flush at level 5 with in_valid; ovf stays set
    for (int k = 0; k < 5; k++) cyc(1'b1, 32'hF000_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ovf", 32'(ovf), 32'd1);
    cyc(1'b1, 32'h5555_6666, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // ovf_clr colliding with a drop: set wins, then plain clear
    for (int k = 0; k < 8; k++) cyc(1'b1, 32'h0700_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b1);
    chk("clr_drop_ovf", 32'(ovf), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < 12; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Wrap and throughput: 40 writes, one per 3 cycles
    for (int k = 0; k < 120; k++) begin
      cyc((k % 3) == 0, 32'h0100_0000 + 32'(k), 1'b1, 1'b0, 1'b0);
      if (level > 4'd1) chk("wrap_level_max", 32'(level), 32'd1);
    end
    for (int k = 0; k < 4; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("wrap_empty", 32'(sb.size()), 32'd0);

    // Backpressure: hold level 4, ready toggling, writes on read cycles
    for (int k = 0; k < 4; k++) cyc(1'b1, 32'h0200_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cyc((k % 2) == 0, 32'h0300_0000 + 32'(k), (k % 2) == 0, 1'b0, 1'b0);
      chk("bp_level", 32'(level), 32'd4);
    end
    for (int k = 0; k < 8; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-stream with ovf set
    for (int k = 0; k < 9; k++) cyc(1'b1, 32'h0400_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    #13 reset = 1'b0;
    sb.delete();
    ovf_exp = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_data", out_data, 32'hCAFE_F00D);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
